// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute stage bus: D-stage values going in, E-stage copies coming out.
// The master side is the surrounding core (decode drives, execute consumes);
// the slave side is the pipeline register itself.
interface id_ex_pipe_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 16
);
  logic                      valid_d;
  logic [DATA_WIDTH-1:0]     rd1_d;
  logic [DATA_WIDTH-1:0]     rd2_d;
  logic [DATA_WIDTH-1:0]     pc_d;
  logic [DATA_WIDTH-1:0]     pc_plus4_d;
  logic [DATA_WIDTH-1:0]     imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;
  logic [CTRL_WIDTH-1:0]     ctrl_d;

  logic                      valid_e;
  logic [DATA_WIDTH-1:0]     rd1_e;
  logic [DATA_WIDTH-1:0]     rd2_e;
  logic [DATA_WIDTH-1:0]     pc_e;
  logic [DATA_WIDTH-1:0]     pc_plus4_e;
  logic [DATA_WIDTH-1:0]     imm_e;
  logic [REG_ADDR_WIDTH-1:0] rs1_e;
  logic [REG_ADDR_WIDTH-1:0] rs2_e;
  logic [REG_ADDR_WIDTH-1:0] rd_e;
  logic [CTRL_WIDTH-1:0]     ctrl_e;

  modport master (
    output valid_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_d, rs1_d, rs2_d, rd_d, ctrl_d,
    input  valid_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e, rs1_e, rs2_e, rd_e, ctrl_e
  );

  modport slave (
    input  valid_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_d, rs1_d, rs2_d, rd_d, ctrl_d,
    output valid_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e, rs1_e, rs2_e, rd_e, ctrl_e
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures the decoded instruction for the execute stage, with stall hold,
// flush/invalid bubble insertion and saturating stall/bubble counters.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 cnt_clr,
  id_ex_pipe_reg_if.slave      bus,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pcPlus4;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [CTRL_WIDTH-1:0]     ctrl;
  } stage_t;

  stage_t               stage_q, stage_d;
  logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_WIDTH-1:0] bubbleCnt_q, bubbleCnt_d;

  // A bubble is an all-zero stage so that ctrl and rd can never leak from an
  // invalid or flushed slot; zero indices also keep forwarding from matching.
  logic loadBubble;
  logic holdStage;

  assign loadBubble = flush_e | (~stall_e & ~bus.valid_d);
  assign holdStage  = stall_e & ~flush_e;

  // Select next E-stage contents: bubble beats hold, hold beats load.
  always_comb begin
    stage_d = stage_q;
    if (loadBubble) begin
      stage_d = '0;
    end else if (!holdStage) begin
      stage_d.valid   = 1'b1;
      stage_d.rd1     = bus.rd1_d;
      stage_d.rd2     = bus.rd2_d;
      stage_d.pc      = bus.pc_d;
      stage_d.pcPlus4 = bus.pc_plus4_d;
      stage_d.imm     = bus.imm_d;
      stage_d.rs1     = bus.rs1_d;
      stage_d.rs2     = bus.rs2_d;
      stage_d.rd      = bus.rd_d;
      stage_d.ctrl    = bus.ctrl_d;
    end
  end

  // Saturating performance counters; a clear request overrides any increment.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (cnt_clr) begin
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
    end else begin
      if (holdStage && (stallCnt_q != '1)) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
      if (loadBubble && (bubbleCnt_q != '1)) begin
        bubbleCnt_d = bubbleCnt_q + 1'b1;
      end
    end
  end

  // State update; reset discards whatever instruction is held or stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign bus.valid_e    = stage_q.valid;
  assign bus.rd1_e      = stage_q.rd1;
  assign bus.rd2_e      = stage_q.rd2;
  assign bus.pc_e       = stage_q.pc;
  assign bus.pc_plus4_e = stage_q.pcPlus4;
  assign bus.imm_e      = stage_q.imm;
  assign bus.rs1_e      = stage_q.rs1;
  assign bus.rs2_e      = stage_q.rs2;
  assign bus.rd_e       = stage_q.rd;
  assign bus.ctrl_e     = stage_q.ctrl;
  assign stall_cnt      = stallCnt_q;
  assign bubble_cnt     = bubbleCnt_q;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised decode-to-execute pipeline register for the 5-stage RV32I core. It sits between the decode stage (register-file read, immediate extend, control decode) and the execute stage (ALU, branch compare). It captures operands, PC values, immediate, register addresses and a packed control bundle, and adds stall, flush and valid-bit bubble handling. It also keeps saturating stall and bubble counters for performance analysis.

Parameters:
DATA_WIDTH, 32, width of operands, PC, PC+4 and immediate
REG_ADDR_WIDTH, 5, width of rs1/rs2/rd register indices
CTRL_WIDTH, 16, width of packed control bundle (RegWrite, MemWrite, ALUControl, ALUSrc, ResultSrc, Branch, Jump, ...)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall_e  in  1  hold the current E-stage contents
flush_e  in  1  load a bubble into the E stage
valid_d  in  1  D-stage holds a real instruction
rd1_d  in  DATA_WIDTH  register-file read data 1
rd2_d  in  DATA_WIDTH  register-file read data 2
pc_d  in  DATA_WIDTH  PC of D-stage instruction
pc_plus4_d  in  DATA_WIDTH  PC+4 of D-stage instruction
imm_d  in  DATA_WIDTH  extended immediate
rs1_d  in  REG_ADDR_WIDTH  source register 1 index
rs2_d  in  REG_ADDR_WIDTH  source register 2 index
rd_d  in  REG_ADDR_WIDTH  destination register index
ctrl_d  in  CTRL_WIDTH  packed control bundle
cnt_clr  in  1  synchronous clear of both counters
valid_e  out  1  E-stage holds a real instruction
rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e  out  DATA_WIDTH each  registered copies of the D-stage values
rs1_e, rs2_e, rd_e  out  REG_ADDR_WIDTH each  registered indices
ctrl_e  out  CTRL_WIDTH  registered control bundle
stall_cnt  out  CNT_WIDTH  cycles spent stalled
bubble_cnt  out  CNT_WIDTH  bubbles inserted

Behaviour:
- Reset: when rst_n=0 at a rising edge, every output register, including both counters, goes to 0. Reset has priority over all other inputs. Reset mid-stall or mid-flush discards the held instruction.
- Update priority at each rising edge with rst_n=1: flush_e, then stall_e, then normal load.
- Flush (flush_e=1, regardless of stall_e):
  - valid_e=0.
  - ctrl_e, rd_e, rs1_e, rs2_e, and all DATA_WIDTH outputs are set to 0.
  - The zeroed indices keep the forwarding unit from matching x0-disabled bubbles.
- Stall (stall_e=1, flush_e=0): all outputs hold their values.
- Normal load (both 0) with valid_d=1: all *_e take the corresponding *_d values and valid_e=1.
- Normal load with valid_d=0: treated exactly as a flush (bubble). An invalid D-stage never leaks control into the E stage.
- Latency: exactly 1 cycle from D inputs to E outputs. No combinational path from input to output.
- Invariant: valid_e=0 implies ctrl_e=0 and rd_e=0.
- stall_cnt:
  - +1 on each edge with rst_n=1, stall_e=1, flush_e=0.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
- bubble_cnt:
  - +1 on each edge where a bubble is loaded (flush_e=1, or stall_e=0 with valid_d=0).
  - Saturates at 2^CNT_WIDTH-1.
- cnt_clr=1 zeroes both counters on that edge. If clear and increment coincide, clear wins. cnt_clr does not affect pipeline data.
- Width rules: all fields are copied bit-exact with no extension. Counters are unsigned.

Test Plan:
- Reset: drive non-zero inputs, rst_n=0 for 2 cycles -> all outputs 0, valid_e=0, counters 0. Release with valid_d=1, pc_d=0x0000_0010 -> next edge pc_e=0x10, valid_e=1.
- Pass-through: rd1_d=0xDEADBEEF, imm_d=0xFFFF_F800, rd_d=5, ctrl_d=0x00A3, valid_d=1 -> one cycle later rd1_e=0xDEADBEEF, imm_e=0xFFFF_F800, rd_e=5, ctrl_e=0x00A3.
- Stall: load pc_d=0x20, then stall_e=1 for 3 cycles while pc_d=0x24, 0x28, 0x2C -> pc_e stays 0x20 and stall_cnt=3. On release, pc_e takes the current pc_d.
- Flush-over-stall: stall_e=1 and flush_e=1 on the same edge with ctrl_e=0x00A3 -> valid_e=0, ctrl_e=0, rd_e=0, bubble_cnt+1, stall_cnt unchanged.
- Invalid input: valid_d=0, ctrl_d=0xFFFF, rd_d=7, stall/flush=0 -> ctrl_e=0, rd_e=0, valid_e=0, bubble_cnt+1.
- Saturation and clear: CNT_WIDTH=4, hold stall 20 cycles -> stall_cnt=15. Assert cnt_clr while stall_e=1 -> stall_cnt=0 on that edge, then 1 on the next edge.
